// File: rtl/ra_ddr_exerciser.sv
// Host-side traffic source for the 4R/2W DDR test array: writes a pattern to every
// word, reads it back on all four read ports and reports mismatch statistics.
module ra_ddr_exerciser #(
    parameter int DEPTH  = 64,
    parameter int ADR_W  = 6,
    parameter int DAT_W  = 72,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       pattern_sel,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       fail_cnt,
    output logic [ADR_W-1:0] fail_adr,
    output logic [1:0]       fail_port,
    output logic             wr_enb_0,
    output logic             wr_enb_1,
    output logic [ADR_W-1:0] wr_adr_0,
    output logic [ADR_W-1:0] wr_adr_1,
    output logic [DAT_W-1:0] wr_dat_0,
    output logic [DAT_W-1:0] wr_dat_1,
    output logic             rd_enb_0,
    output logic             rd_enb_1,
    output logic             rd_enb_2,
    output logic             rd_enb_3,
    output logic [ADR_W-1:0] rd_adr_0,
    output logic [ADR_W-1:0] rd_adr_1,
    output logic [ADR_W-1:0] rd_adr_2,
    output logic [ADR_W-1:0] rd_adr_3,
    input  logic [DAT_W-1:0] rd_dat_0,
    input  logic [DAT_W-1:0] rd_dat_1,
    input  logic [DAT_W-1:0] rd_dat_2,
    input  logic [DAT_W-1:0] rd_dat_3
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

    state_e                        state_q, state_d;
    logic [ADR_W-1:0]              cnt_q, cnt_d;
    logic [1:0]                    pat_q, pat_d;
    logic                          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [7:0]                    fail_cnt_q, fail_cnt_d;
    logic [ADR_W-1:0]              fail_adr_q, fail_adr_d;
    logic [1:0]                    fail_port_q, fail_port_d;
    logic [1:0]                    wr_enb_q, wr_enb_d;
    logic [1:0][ADR_W-1:0]         wr_adr_q, wr_adr_d;
    logic [1:0][DAT_W-1:0]         wr_dat_q, wr_dat_d;
    logic [3:0]                    rd_enb_q, rd_enb_d;
    logic [3:0][ADR_W-1:0]         rd_adr_q, rd_adr_d;
    logic [RD_LAT-1:0][3:0]        vld_pipe_q;
    logic [RD_LAT-1:0][3:0][ADR_W-1:0] adr_pipe_q;
    logic [3:0][DAT_W-1:0]         rd_dat;
    logic [3:0]                    mis;
    logic [2:0]                    nmis;
    logic [8:0]                    sum;
    logic                          go;

    assign rd_dat = {rd_dat_3, rd_dat_2, rd_dat_1, rd_dat_0};

    function automatic logic [DAT_W-1:0] pat_f(input logic [1:0] sel, input logic [ADR_W-1:0] a);
        logic [DAT_W-1:0] d;
        d = '0;
        case (sel)
            2'd0: d = '0;
            2'd1: d = '1;
            2'd2: for (int i = 0; i < DAT_W; i++) d[i] = (i % 2 == 1) ^ a[0];
            default: d = {(DAT_W/ADR_W){a}};
        endcase
        return d;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go      = (state_q == IDLE) && start;
        pat_d   = go ? pattern_sel : pat_q;
        case (state_q)
            IDLE:  if (start) begin state_d = WRITE; cnt_d = '0; end
            WRITE: if (cnt_q == ADR_W'(DEPTH/2-1)) begin state_d = READ; cnt_d = '0; end
                   else cnt_d = cnt_q + 1'b1;
            READ:  if (cnt_q == ADR_W'(DEPTH/4-1)) begin state_d = DRAIN; cnt_d = '0; end
                   else cnt_d = cnt_q + 1'b1;
            DRAIN: if (cnt_q == ADR_W'(RD_LAT-1)) begin state_d = DONE; cnt_d = '0; end
                   else cnt_d = cnt_q + 1'b1;
            default: begin state_d = IDLE; cnt_d = '0; end
        endcase

        // Output registers are loaded from the next state so each beat lines up with its state.
        wr_enb_d = '0; wr_adr_d = '0; wr_dat_d = '0;
        rd_enb_d = '0; rd_adr_d = '0;
        if (state_d == WRITE) begin
            for (int w = 0; w < 2; w++) begin
                wr_enb_d[w] = 1'b1;
                wr_adr_d[w] = {cnt_d[ADR_W-2:0], 1'(w)};
                wr_dat_d[w] = pat_f(pat_d, wr_adr_d[w]);
            end
        end
        if (state_d == READ) begin
            for (int n = 0; n < 4; n++) begin
                rd_enb_d[n] = 1'b1;
                rd_adr_d[n] = {cnt_d[ADR_W-3:0], 2'(n)};
            end
        end

        nmis = '0;
        for (int n = 0; n < 4; n++) begin
            mis[n] = vld_pipe_q[RD_LAT-1][n] &&
                     (rd_dat[n] != pat_f(pat_q, adr_pipe_q[RD_LAT-1][n]));
            nmis   = nmis + 3'(mis[n]);
        end
        sum = {1'b0, fail_cnt_q} + 9'(nmis);

        fail_cnt_d  = sum[8] ? 8'hFF : sum[7:0];
        fail_adr_d  = fail_adr_q;
        fail_port_d = fail_port_q;
        // A saturating count never returns to zero, so zero means no mismatch yet this run.
        if (fail_cnt_q == 8'd0) begin
            for (int n = 3; n >= 0; n--) begin
                if (mis[n]) begin
                    fail_adr_d  = adr_pipe_q[RD_LAT-1][n];
                    fail_port_d = 2'(n);
                end
            end
        end
        pass_d = pass_q;
        if (go) begin
            fail_cnt_d = '0; fail_adr_d = '0; fail_port_d = '0; pass_d = 1'b0;
        end else if (state_d == DONE) begin
            pass_d = (fail_cnt_d == 8'd0);
        end
        busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_cnt_q  <= '0;
            fail_adr_q  <= '0;
            fail_port_q <= '0;
            wr_enb_q    <= '0;
            wr_adr_q    <= '0;
            wr_dat_q    <= '0;
            rd_enb_q    <= '0;
            rd_adr_q    <= '0;
            vld_pipe_q  <= '0;
            adr_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_adr_q  <= fail_adr_d;
            fail_port_q <= fail_port_d;
            wr_enb_q    <= wr_enb_d;
            wr_adr_q    <= wr_adr_d;
            wr_dat_q    <= wr_dat_d;
            rd_enb_q    <= rd_enb_d;
            rd_adr_q    <= rd_adr_d;
            vld_pipe_q[0] <= rd_enb_q;
            adr_pipe_q[0] <= rd_adr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                adr_pipe_q[i] <= adr_pipe_q[i-1];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_cnt  = fail_cnt_q;
    assign fail_adr  = fail_adr_q;
    assign fail_port = fail_port_q;
    assign wr_enb_0  = wr_enb_q[0];
    assign wr_enb_1  = wr_enb_q[1];
    assign wr_adr_0  = wr_adr_q[0];
    assign wr_adr_1  = wr_adr_q[1];
    assign wr_dat_0  = wr_dat_q[0];
    assign wr_dat_1  = wr_dat_q[1];
    assign rd_enb_0  = rd_enb_q[0];
    assign rd_enb_1  = rd_enb_q[1];
    assign rd_enb_2  = rd_enb_q[2];
    assign rd_enb_3  = rd_enb_q[3];
    assign rd_adr_0  = rd_adr_q[0];
    assign rd_adr_1  = rd_adr_q[1];
    assign rd_adr_2  = rd_adr_q[2];
    assign rd_adr_3  = rd_adr_q[3];

endmodule
